// File: rtl/readout_sequencer_if.sv
// RAM read port and host byte stream of the readout sequencer, bundled as one interface.
interface readout_sequencer_if #(
  parameter int RAM_WIDTH = 10
);
  logic                 rden;
  logic [RAM_WIDTH-1:0] rdaddress;
  logic [31:0]          ram_q;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output rden, rdaddress, tx_data, tx_valid,
    input  ram_q, tx_ready
  );

  modport slave (
    input  rden, rdaddress, tx_data, tx_valid,
    output ram_q, tx_ready
  );
endinterface

// File: rtl/readout_sequencer.sv
// Streams enabled channels of the circular sample RAM from (trigger - pretrigger) to the host.
// Latency RD_LAT+1 cycles from rden to tx_valid; reads are issued only into reserved FIFO slots.
module readout_sequencer #(
  parameter int RAM_WIDTH  = 10,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 read_req,
  input  logic                 read_abort,
  input  logic                 auto_rearm,
  input  logic [3:0]           chan_mask,
  input  logic                 data_ready,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  input  logic [RAM_WIDTH-1:0] nsmp,
  output logic                 start_trigger,
  output logic                 busy,
  output logic                 done,
  readout_sequencer_if.master  bus
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_FINISH   = 3'd4;

  logic [2:0]           state;
  logic [3:0]           mask_l;
  logic [RAM_WIDTH-1:0] nsmp_l;
  logic [RAM_WIDTH-1:0] base;
  logic                 rearm_l;
  logic [1:0]           chan;
  logic [RAM_WIDTH-1:0] addr;
  logic [RAM_WIDTH-1:0] cnt;

  logic                 pipe_vld  [RD_LAT];
  logic [1:0]           pipe_chan [RD_LAT];
  logic [CW-1:0]        inflight;

  logic [7:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_count;

  logic [CW:0]          occ;
  logic                 issue;
  logic                 last_smp;
  logic                 push;
  logic                 pop;
  logic                 do_push;
  logic [7:0]           push_dat;
  logic [1:0]           first_chan;
  logic [1:0]           nxt_chan;
  logic                 nxt_found;

  // Outstanding reads already own a FIFO slot, so a full FIFO can never be overrun.
  assign occ      = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue    = (state == S_ISSUE) && (occ < DEPTH_W);
  assign last_smp = (cnt + RAM_WIDTH'(1)) == nsmp_l;
  assign push     = pipe_vld[RD_LAT-1];
  assign push_dat = bus.ram_q[{pipe_chan[RD_LAT-1], 3'b000} +: 8];
  assign pop      = bus.tx_valid && bus.tx_ready;
  assign do_push  = push && ((fifo_count != CW'(FIFO_DEPTH)) || pop);

  assign bus.rden      = issue;
  assign bus.rdaddress = addr;
  assign bus.tx_valid  = (fifo_count != '0);
  assign bus.tx_data   = fifo_mem[rd_ptr];
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_FINISH);
  assign start_trigger = (state == S_FINISH) && rearm_l;

  always_comb begin
    first_chan = 2'd0;
    nxt_chan   = chan;
    nxt_found  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_l[i]) first_chan = 2'(i);
      if (mask_l[i] && (i > int'(chan))) begin
        nxt_chan  = 2'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      mask_l  <= '0;
      nsmp_l  <= '0;
      base    <= '0;
      rearm_l <= 1'b0;
      chan    <= '0;
      addr    <= '0;
      cnt     <= '0;
    end else if (read_abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (read_req) begin
            mask_l  <= chan_mask;
            nsmp_l  <= nsmp;
            base    <= wraddress_triggerpoint - triggerpoint;
            rearm_l <= auto_rearm;
            state   <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (data_ready) begin
            if ((mask_l == '0) || (nsmp_l == '0)) begin
              state <= S_FINISH;
            end else begin
              chan  <= first_chan;
              addr  <= base;
              cnt   <= '0;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (issue) begin
            if (last_smp) begin
              addr <= base;
              cnt  <= '0;
              if (nxt_found) chan  <= nxt_chan;
              else           state <= S_DRAIN;
            end else begin
              addr <= addr + RAM_WIDTH'(1);
              cnt  <= cnt + RAM_WIDTH'(1);
            end
          end
        end
        S_DRAIN: begin
          if ((inflight == '0) && (fifo_count == '0)) state <= S_FINISH;
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Channel tag travels with each read so the right byte lane is picked when ram_q arrives.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_chan[i] <= '0;
      end
      inflight <= '0;
    end else if (read_abort) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_chan[i] <= '0;
      end
      inflight <= '0;
    end else begin
      pipe_vld[0]  <= issue;
      pipe_chan[0] <= chan;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_chan[i] <= pipe_chan[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(push);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (read_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) begin
        fifo_mem[wr_ptr] <= push_dat;
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(do_push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a 2-cycle RAM model and byte/address scoreboards.
module tb_readout_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       read_req;
  logic       read_abort;
  logic       auto_rearm;
  logic [3:0] chan_mask;
  logic       data_ready;
  logic [9:0] trig_addr;
  logic [9:0] trig_pt;
  logic [9:0] nsmp;
  logic       start_trigger;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  readout_sequencer_if #(.RAM_WIDTH(10)) bus ();

  readout_sequencer #(.RAM_WIDTH(10), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .read_req               (read_req),
    .read_abort             (read_abort),
    .auto_rearm             (auto_rearm),
    .chan_mask              (chan_mask),
    .data_ready             (data_ready),
    .wraddress_triggerpoint (trig_addr),
    .triggerpoint           (trig_pt),
    .nsmp                   (nsmp),
    .start_trigger          (start_trigger),
    .busy                   (busy),
    .done                   (done),
    .bus                    (bus)
  );

  logic [31:0] mem [1024];
  logic [31:0] q1;
  always @(posedge clk) begin
    if (bus.rden) q1 <= mem[bus.rdaddress];
    bus.ram_q <= q1;
  end

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int st_cnt = 0;
  int max_out = 0;
  int outst;
  logic [9:0] raddr [$];
  logic [7:0] rx [$];

  always @(negedge clk) begin
    if (bus.rden) raddr.push_back(bus.rdaddress);
    if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
    if (done) done_cnt++;
    if (start_trigger) st_cnt++;
    outst = raddr.size() - rx.size();
    if (outst > max_out) max_out = outst;
  end

  function automatic logic [7:0] eb(input int ch, input int a);
    return 8'((a * 5 + ch * 67 + 11) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [3:0] m, input int n, input int ta, input int tp, input logic rearm);
    raddr.delete();
    rx.delete();
    done_cnt   = 0;
    st_cnt     = 0;
    max_out    = 0;
    chan_mask  = m;
    nsmp       = 10'(n);
    trig_addr  = 10'(ta);
    trig_pt    = 10'(tp);
    auto_rearm = rearm;
    read_req   = 1'b1;
    tick(1);
    read_req   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      tick(1);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != 0), 1);
    tick(2);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic check_stream(input string tag, input logic [3:0] m, input int n, input int base);
    int idx = 0;
    int a;
    chk({tag, "_nbytes"}, rx.size(), $countones(m) * n);
    chk({tag, "_nreads"}, raddr.size(), $countones(m) * n);
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        for (int i = 0; i < n; i++) begin
          a = (base + i) % 1024;
          if (idx < rx.size())    chk({tag, "_data"}, rx[idx], eb(ch, a));
          if (idx < raddr.size()) chk({tag, "_addr"}, raddr[idx], a);
          idx++;
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = {eb(3, a), eb(2, a), eb(1, a), eb(0, a)};
    rstn        = 1'b0;
    read_req    = 1'b0;
    read_abort  = 1'b0;
    auto_rearm  = 1'b0;
    chan_mask   = 4'd0;
    data_ready  = 1'b1;
    trig_addr   = '0;
    trig_pt     = '0;
    nsmp        = '0;
    bus.tx_ready = 1'b1;
    tick(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_rden", 32'(bus.rden), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start_trigger", 32'(start_trigger), 0);
    chk("rst_rdaddress", 32'(bus.rdaddress), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    rstn = 1'b1;
    tick(2);

    // Single channel, base = 5 - 3 = 2.
    start(4'b0001, 8, 5, 3, 1'b0);
    wait_done("t1", 200);
    check_stream("t1", 4'b0001, 8, 2);
    chk("t1_no_rearm", st_cnt, 0);

    // Base wraps: 2 - 5 = 1021.
    start(4'b0001, 6, 2, 5, 1'b0);
    wait_done("t2", 200);
    check_stream("t2", 4'b0001, 6, 1021);

    // Channels 2 and 4; data_ready drops mid-readout and is ignored.
    start(4'b1010, 4, 100, 0, 1'b0);
    tick(4);
    data_ready = 1'b0;
    wait_done("t3", 200);
    data_ready = 1'b1;
    check_stream("t3", 4'b1010, 4, 100);

    // Backpressure: stall 50 cycles, then random ready.
    start(4'b0011, 10, 500, 20, 1'b0);
    tick(5);
    bus.tx_ready = 1'b0;
    tick(50);
    chk("t4_stalled_outstanding", raddr.size() - rx.size(), 4);
    chk("t4_tx_valid_held", 32'(bus.tx_valid), 1);
    chk("t4_busy_stalled", 32'(busy), 1);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    bus.tx_ready = 1'b1;
    wait_done("t4", 100);
    chk("t4_max_outstanding_le4", 32'(max_out <= 4), 1);
    check_stream("t4", 4'b0011, 10, 480);

    // Empty mask with re-arm: pulses only.
    start(4'b0000, 8, 0, 0, 1'b1);
    wait_done("t5", 50);
    chk("t5_start_trigger_once", st_cnt, 1);
    chk("t5_nbytes", rx.size(), 0);
    chk("t5_nreads", raddr.size(), 0);

    // Abort mid-ISSUE, then a normal readout.
    start(4'b1111, 20, 10, 0, 1'b1);
    tick(6);
    read_abort = 1'b1;
    tick(1);
    read_abort = 1'b0;
    chk("t6_abort_tx_valid", 32'(bus.tx_valid), 0);
    chk("t6_abort_busy", 32'(busy), 0);
    tick(20);
    chk("t6_abort_no_done", done_cnt, 0);
    chk("t6_abort_no_trigger", st_cnt, 0);
    chk("t6_abort_rden_idle", 32'(bus.rden), 0);
    start(4'b0100, 3, 30, 4, 1'b0);
    wait_done("t6", 200);
    check_stream("t6", 4'b0100, 3, 26);

    // Reset mid-ISSUE, then a normal readout with re-arm.
    start(4'b1000, 30, 0, 0, 1'b1);
    tick(6);
    rstn = 1'b0;
    #1;
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("t7_rst_rden", 32'(bus.rden), 0);
    tick(2);
    rstn = 1'b1;
    tick(3);
    chk("t7_rst_no_done", done_cnt, 0);
    chk("t7_rst_no_trigger", st_cnt, 0);
    start(4'b0001, 5, 1, 1, 1'b1);
    wait_done("t7", 200);
    check_stream("t7", 4'b0001, 5, 0);
    chk("t7_start_trigger_once", st_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
